// File: rtl/bus_arbiter_n.sv
// N-channel arbiter (fixed priority or round-robin) of single-outstanding requesters onto one bus.
// Latency: start->bus_start 1 cycle, bus_ready->req_ready 0 cycles; starts during a busy bus wait in per-channel slots.
module bus_arbiter_n #(
    parameter int N      = 2,
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32,
    parameter int RR     = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N-1:0]            req_start,
    input  logic [N-1:0]            req_write,
    input  logic [N*ADDR_W-1:0]     req_addr,
    input  logic [N*DATA_W-1:0]     req_data_wr,
    input  logic [N*DATA_W/8-1:0]   req_be,
    output logic [N-1:0]            req_ready,
    output logic [DATA_W-1:0]       req_data_rd,
    output logic [N-1:0]            overrun,
    output logic [ADDR_W-1:0]       bus_addr,
    output logic                    bus_start,
    output logic                    bus_write,
    output logic [DATA_W-1:0]       bus_data_wr,
    output logic [DATA_W/8-1:0]     bus_data_be,
    input  logic                    bus_ready,
    input  logic [DATA_W-1:0]       bus_data_rd,
    output logic                    busy,
    output logic [$clog2(N)-1:0]    grant
);
    localparam int BE_W = DATA_W / 8;
    localparam int GW   = $clog2(N);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
    state_t state, state_nxt;

    logic [N-1:0]        pending, accept, done, eligible;
    logic [N-1:0]        slot_write;
    logic [ADDR_W-1:0]   slot_addr [N];
    logic [DATA_W-1:0]   slot_data [N];
    logic [BE_W-1:0]     slot_be   [N];
    logic [ADDR_W-1:0]   in_addr   [N];
    logic [DATA_W-1:0]   in_data   [N];
    logic [BE_W-1:0]     in_be     [N];
    logic [ADDR_W-1:0]   eff_addr  [N];
    logic [DATA_W-1:0]   eff_data  [N];
    logic [BE_W-1:0]     eff_be    [N];
    logic [N-1:0]        eff_write;
    logic                completing, arb_point, found;
    logic [GW-1:0]       last_grant, winner, idx;
    int                  base;

    // A start loaded this cycle must be usable by this cycle's arbitration,
    // so the winner's fields come from the inputs or the slot accordingly.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            in_addr[i]   = req_addr[i*ADDR_W +: ADDR_W];
            in_data[i]   = req_data_wr[i*DATA_W +: DATA_W];
            in_be[i]     = req_be[i*BE_W +: BE_W];
            eff_addr[i]  = accept[i] ? in_addr[i] : slot_addr[i];
            eff_data[i]  = accept[i] ? in_data[i] : slot_data[i];
            eff_be[i]    = accept[i] ? in_be[i]   : slot_be[i];
            eff_write[i] = accept[i] ? req_write[i] : slot_write[i];
        end
    end

    always_comb begin
        completing = (state == S_WAIT) && bus_ready && !rst;
        done       = '0;
        if (completing) done[grant] = 1'b1;
        // The completing channel may re-arm in its own bus_ready cycle.
        accept     = req_start & (~pending | done);
        eligible   = (pending & ~done) | accept;
        arb_point  = (state == S_IDLE) || completing;
    end

    // Fixed priority is round-robin with the search always starting after N-1.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        base   = (RR != 0) ? int'(last_grant) : N - 1;
        for (int k = 1; k <= N; k++) begin
            idx = GW'((base + k) % N);
            if (!found && eligible[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (found) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (bus_ready) state_nxt = found ? S_ISSUE : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            pending     <= '0;
            overrun     <= '0;
            grant       <= '0;
            last_grant  <= GW'(N - 1);
            bus_addr    <= '0;
            bus_write   <= 1'b0;
            bus_data_wr <= '0;
            bus_data_be <= '0;
            slot_write  <= '0;
            for (int i = 0; i < N; i++) begin
                slot_addr[i] <= '0;
                slot_data[i] <= '0;
                slot_be[i]   <= '0;
            end
        end else begin
            state   <= state_nxt;
            pending <= eligible;
            overrun <= overrun | (req_start & ~accept);
            for (int i = 0; i < N; i++) begin
                if (accept[i]) begin
                    slot_write[i] <= req_write[i];
                    slot_addr[i]  <= in_addr[i];
                    slot_data[i]  <= in_data[i];
                    slot_be[i]    <= in_be[i];
                end
            end
            if (arb_point && found) begin
                grant       <= winner;
                last_grant  <= winner;
                bus_addr    <= eff_addr[winner];
                bus_write   <= eff_write[winner];
                bus_data_wr <= eff_data[winner];
                bus_data_be <= eff_be[winner];
            end
        end
    end

    assign req_ready   = done;
    assign req_data_rd = completing ? bus_data_rd : '0;
    assign bus_start   = (state == S_ISSUE);
    assign busy        = (state != S_IDLE);
endmodule

// File: tb/tb_bus_arbiter_n.sv
// Bench for bus_arbiter_n: instance 0 round-robin, instance 1 fixed priority, both N=4.
module tb_bus_arbiter_n;
    localparam int N = 4, AW = 30, DW = 32, BW = 4;

    logic clk, rst;
    logic [N-1:0]    req_start [2];
    logic [N-1:0]    req_write [2];
    logic [N*AW-1:0] req_addr [2];
    logic [N*DW-1:0] req_data_wr [2];
    logic [N*BW-1:0] req_be [2];
    logic [N-1:0]    req_ready [2];
    logic [DW-1:0]   req_data_rd [2];
    logic [N-1:0]    overrun [2];
    logic [AW-1:0]   bus_addr [2];
    logic            bus_start [2];
    logic            bus_write [2];
    logic [DW-1:0]   bus_data_wr [2];
    logic [BW-1:0]   bus_data_be [2];
    logic            bus_ready [2];
    logic [DW-1:0]   bus_data_rd [2];
    logic            busy [2];
    logic [1:0]      grant [2];

    int total = 0;
    int bad = 0;

    bus_arbiter_n #(.N(N), .ADDR_W(AW), .DATA_W(DW), .RR(1)) u_rr (
        .clk(clk), .rst(rst), .req_start(req_start[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_data_wr(req_data_wr[0]), .req_be(req_be[0]),
        .req_ready(req_ready[0]), .req_data_rd(req_data_rd[0]), .overrun(overrun[0]),
        .bus_addr(bus_addr[0]), .bus_start(bus_start[0]), .bus_write(bus_write[0]),
        .bus_data_wr(bus_data_wr[0]), .bus_data_be(bus_data_be[0]), .bus_ready(bus_ready[0]),
        .bus_data_rd(bus_data_rd[0]), .busy(busy[0]), .grant(grant[0]));

    bus_arbiter_n #(.N(N), .ADDR_W(AW), .DATA_W(DW), .RR(0)) u_fp (
        .clk(clk), .rst(rst), .req_start(req_start[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_data_wr(req_data_wr[1]), .req_be(req_be[1]),
        .req_ready(req_ready[1]), .req_data_rd(req_data_rd[1]), .overrun(overrun[1]),
        .bus_addr(bus_addr[1]), .bus_start(bus_start[1]), .bus_write(bus_write[1]),
        .bus_data_wr(bus_data_wr[1]), .bus_data_be(bus_data_be[1]), .bus_ready(bus_ready[1]),
        .bus_data_rd(bus_data_rd[1]), .busy(busy[1]), .grant(grant[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            req_start[s] = '0;
            bus_ready[s] = 1'b0;
            bus_data_rd[s] = '0;
        end
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic start(input int sel, input int ch, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [BW-1:0] be);
        req_start[sel][ch] = 1'b1;
        req_write[sel][ch] = wr;
        req_addr[sel][ch*AW +: AW] = a;
        req_data_wr[sel][ch*DW +: DW] = d;
        req_be[sel][ch*BW +: BW] = be;
    endtask

    task automatic test_reset();
        do_reset();
        settle();
        for (int s = 0; s < 2; s++) begin
            total++; if (bus_start[s] !== 1'b0) begin bad++; $display("FAIL rst_bus_start[%0d]: got %b want 0", s, bus_start[s]); end
            total++; if (busy[s] !== 1'b0) begin bad++; $display("FAIL rst_busy[%0d]: got %b want 0", s, busy[s]); end
            total++; if (grant[s] !== 2'd0) begin bad++; $display("FAIL rst_grant[%0d]: got %0d want 0", s, grant[s]); end
            total++; if (overrun[s] !== 4'b0) begin bad++; $display("FAIL rst_overrun[%0d]: got %b want 0", s, overrun[s]); end
            total++; if (req_ready[s] !== 4'b0) begin bad++; $display("FAIL rst_req_ready[%0d]: got %b want 0", s, req_ready[s]); end
            total++; if ({bus_addr[s], bus_write[s], bus_data_wr[s], bus_data_be[s]} !== '0) begin
                bad++; $display("FAIL rst_bus_fields[%0d]: got %h/%b/%h/%h want 0", s, bus_addr[s], bus_write[s], bus_data_wr[s], bus_data_be[s]); end
            total++; if (req_data_rd[s] !== 32'h0) begin bad++; $display("FAIL rst_req_data_rd[%0d]: got %h want 0", s, req_data_rd[s]); end
        end
    endtask

    task automatic test_single_read();
        do_reset();
        start(0, 1, 1'b0, 'h100, 32'h0, 4'hF);
        settle();
        total++; if (bus_start[0] !== 1'b0) begin bad++; $display("FAIL sr_early_start: got %b want 0", bus_start[0]); end
        tick(); settle();
        total++; if (bus_start[0] !== 1'b1) begin bad++; $display("FAIL sr_bus_start: got %b want 1", bus_start[0]); end
        total++; if (bus_addr[0] !== 30'h100) begin bad++; $display("FAIL sr_addr: got %h want 100", bus_addr[0]); end
        total++; if (busy[0] !== 1'b1 || grant[0] !== 2'd1) begin bad++; $display("FAIL sr_busy_grant: got %b/%0d want 1/1", busy[0], grant[0]); end
        for (int k = 0; k < 2; k++) begin
            tick(); settle();
            total++; if (bus_start[0] !== 1'b0 || bus_addr[0] !== 30'h100 || req_ready[0] !== 4'b0) begin
                bad++; $display("FAIL sr_hold: got start=%b addr=%h rdy=%b want 0/100/0", bus_start[0], bus_addr[0], req_ready[0]); end
        end
        tick();
        bus_ready[0] = 1'b1; bus_data_rd[0] = 32'hDEADBEEF;
        settle();
        total++; if (req_ready[0] !== 4'b0010) begin bad++; $display("FAIL sr_req_ready: got %b want 0010", req_ready[0]); end
        total++; if (req_data_rd[0] !== 32'hDEADBEEF) begin bad++; $display("FAIL sr_rdata: got %h want deadbeef", req_data_rd[0]); end
        total++; if (bus_addr[0] !== 30'h100) begin bad++; $display("FAIL sr_addr_at_ready: got %h want 100", bus_addr[0]); end
        tick(); settle();
        total++; if (busy[0] !== 1'b0 || req_ready[0] !== 4'b0) begin bad++; $display("FAIL sr_idle_after: got busy=%b rdy=%b want 0/0", busy[0], req_ready[0]); end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int ch = 0; ch < N; ch++) start(0, ch, 1'b0, AW'(ch * 16 + 1), 32'h0, 4'hF);
        settle();
        for (int k = 0; k < N; k++) begin
            tick(); settle();
            total++; if (bus_start[0] !== 1'b1 || grant[0] !== 2'(k) || bus_addr[0] !== AW'(k * 16 + 1)) begin
                bad++; $display("FAIL rr_grant%0d: got start=%b grant=%0d addr=%h want 1/%0d/%h", k, bus_start[0], grant[0], bus_addr[0], k, k * 16 + 1); end
            tick();
            bus_ready[0] = 1'b1; bus_data_rd[0] = 32'(k);
            settle();
            total++; if (req_ready[0] !== 4'(1 << k)) begin bad++; $display("FAIL rr_ready%0d: got %b want %b", k, req_ready[0], 4'(1 << k)); end
        end
        tick(); settle();
        total++; if (busy[0] !== 1'b0) begin bad++; $display("FAIL rr_idle: got %b want 0", busy[0]); end
    endtask

    task automatic test_fixed_priority();
        do_reset();
        start(1, 2, 1'b0, 'h22, 32'h0, 4'hF);
        tick(); settle();
        total++; if (bus_start[1] !== 1'b1 || grant[1] !== 2'd2) begin bad++; $display("FAIL fp_first: got %b/%0d want 1/2", bus_start[1], grant[1]); end
        tick(); start(1, 3, 1'b0, 'h33, 32'h0, 4'hF);
        tick(); start(1, 1, 1'b0, 'h11, 32'h0, 4'hF);
        tick(); bus_ready[1] = 1'b1; settle();
        total++; if (req_ready[1] !== 4'b0100) begin bad++; $display("FAIL fp_ready2: got %b want 0100", req_ready[1]); end
        tick(); settle();
        total++; if (bus_start[1] !== 1'b1 || grant[1] !== 2'd1 || bus_addr[1] !== 30'h11) begin
            bad++; $display("FAIL fp_second: got %b/%0d/%h want 1/1/11", bus_start[1], grant[1], bus_addr[1]); end
        tick(); bus_ready[1] = 1'b1; settle();
        total++; if (req_ready[1] !== 4'b0010) begin bad++; $display("FAIL fp_ready1: got %b want 0010", req_ready[1]); end
        tick(); settle();
        total++; if (bus_start[1] !== 1'b1 || grant[1] !== 2'd3 || bus_addr[1] !== 30'h33) begin
            bad++; $display("FAIL fp_third: got %b/%0d/%h want 1/3/33", bus_start[1], grant[1], bus_addr[1]); end
        tick(); bus_ready[1] = 1'b1; settle();
        tick(); settle();
        total++; if (busy[1] !== 1'b0 || overrun[1] !== 4'b0) begin bad++; $display("FAIL fp_end: got busy=%b ovr=%b want 0/0", busy[1], overrun[1]); end
    endtask

    task automatic test_overrun();
        do_reset();
        start(0, 0, 1'b0, 'h10, 32'h0, 4'hF);
        tick();
        tick(); start(0, 0, 1'b0, 'h20, 32'h0, 4'hF);
        tick(); settle();
        total++; if (overrun[0] !== 4'b0001) begin bad++; $display("FAIL ov_flag: got %b want 0001", overrun[0]); end
        total++; if (bus_addr[0] !== 30'h10) begin bad++; $display("FAIL ov_addr: got %h want 10", bus_addr[0]); end
        tick(); bus_ready[0] = 1'b1; settle();
        total++; if (req_ready[0] !== 4'b0001) begin bad++; $display("FAIL ov_ready: got %b want 0001", req_ready[0]); end
        for (int k = 0; k < 3; k++) begin
            tick(); settle();
            total++; if (bus_start[0] !== 1'b0 || busy[0] !== 1'b0 || overrun[0] !== 4'b0001) begin
                bad++; $display("FAIL ov_dropped: got start=%b busy=%b ovr=%b want 0/0/0001", bus_start[0], busy[0], overrun[0]); end
        end
        do_reset();
        start(0, 0, 1'b0, 'h30, 32'h0, 4'hF);
        tick();
        tick(); bus_ready[0] = 1'b1; start(0, 0, 1'b0, 'h40, 32'h0, 4'hF); settle();
        total++; if (req_ready[0] !== 4'b0001) begin bad++; $display("FAIL ov_restart_ready: got %b want 0001", req_ready[0]); end
        tick(); settle();
        total++; if (bus_start[0] !== 1'b1 || bus_addr[0] !== 30'h40 || overrun[0] !== 4'b0) begin
            bad++; $display("FAIL ov_restart: got %b/%h/%b want 1/40/0000", bus_start[0], bus_addr[0], overrun[0]); end
        tick(); bus_ready[0] = 1'b1;
    endtask

    task automatic test_reset_mid();
        do_reset();
        start(0, 2, 1'b1, 'h50, 32'hCAFE, 4'h3);
        tick();
        tick(); start(0, 1, 1'b0, 'h60, 32'h0, 4'hF);
        tick(); rst = 1'b1;
        tick(); rst = 1'b0; settle();
        total++; if (bus_start[0] !== 1'b0 || busy[0] !== 1'b0 || grant[0] !== 2'd0 || overrun[0] !== 4'b0) begin
            bad++; $display("FAIL rm_outputs: got start=%b busy=%b grant=%0d ovr=%b want 0", bus_start[0], busy[0], grant[0], overrun[0]); end
        total++; if ({bus_addr[0], bus_write[0], bus_data_wr[0], bus_data_be[0]} !== '0) begin
            bad++; $display("FAIL rm_bus_fields: got %h/%b/%h/%h want 0", bus_addr[0], bus_write[0], bus_data_wr[0], bus_data_be[0]); end
        tick(); bus_ready[0] = 1'b1; bus_data_rd[0] = 32'h12345678; settle();
        total++; if (req_ready[0] !== 4'b0 || req_data_rd[0] !== 32'h0) begin
            bad++; $display("FAIL rm_late_ready: got %b/%h want 0/0", req_ready[0], req_data_rd[0]); end
        for (int k = 0; k < 4; k++) begin
            tick(); settle();
            total++; if (bus_start[0] !== 1'b0 || busy[0] !== 1'b0) begin
                bad++; $display("FAIL rm_discard: got start=%b busy=%b want 0/0", bus_start[0], busy[0]); end
        end
    endtask

    task automatic test_write_be();
        do_reset();
        start(0, 2, 1'b0, 'h70, 32'h0, 4'hF);
        tick();
        tick();
        start(0, 0, 1'b0, 'h80, 32'h0, 4'hF);
        start(0, 1, 1'b1, 'h90, 32'h11223344, 4'b0101);
        tick(); bus_ready[0] = 1'b1;
        tick();
        tick(); bus_ready[0] = 1'b1; settle();
        total++; if (req_ready[0] !== 4'b0001) begin bad++; $display("FAIL wb_ch0_ready: got %b want 0001", req_ready[0]); end
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k == 3) bus_ready[0] = 1'b1;
            settle();
            total++; if (grant[0] !== 2'd1 || bus_write[0] !== 1'b1 || bus_addr[0] !== 30'h90 ||
                         bus_data_wr[0] !== 32'h11223344 || bus_data_be[0] !== 4'b0101 || bus_start[0] !== (k == 0)) begin
                bad++; $display("FAIL wb_hold%0d: got g=%0d w=%b a=%h d=%h be=%b s=%b want 1/1/90/11223344/0101/%b",
                                k, grant[0], bus_write[0], bus_addr[0], bus_data_wr[0], bus_data_be[0], bus_start[0], k == 0); end
        end
        total++; if (req_ready[0] !== 4'b0010) begin bad++; $display("FAIL wb_ready: got %b want 0010", req_ready[0]); end
    endtask

    // Reference model: per-channel request table, current transaction, next pick by rule.
    task automatic test_random(input int sel, input int cycles);
        bit mp [N];
        logic mw [N];
        logic [AW-1:0] ma [N];
        logic [DW-1:0] md [N];
        logic [BW-1:0] mb [N];
        int st, g, last, cd, w;
        logic [N-1:0] ovr, st_in, exp_rdy;
        logic [AW-1:0] ba;
        logic bw;
        logic [DW-1:0] bd, rdata, exp_rd;
        logic [BW-1:0] bb;
        logic [31:0] r;
        bit comp;
        do_reset();
        for (int i = 0; i < N; i++) mp[i] = 0;
        st = 0; g = 0; last = N - 1; cd = 0; ovr = '0;
        ba = '0; bw = 1'b0; bd = '0; bb = '0;
        for (int c = 0; c < cycles; c++) begin
            tick();
            for (int ch = 0; ch < N; ch++)
                if ($urandom_range(0, 3) == 0) begin
                    r = $urandom;
                    start(sel, ch, 1'($urandom_range(0, 1)), r[AW-1:0], $urandom, 4'($urandom_range(0, 15)));
                end
            if (st == 2) begin
                if (cd == 0) bus_ready[sel] = 1'b1;
                else cd--;
            end else bus_ready[sel] = ($urandom_range(0, 3) == 0);
            rdata = $urandom;
            bus_data_rd[sel] = rdata;
            settle();
            comp = (st == 2) && bus_ready[sel];
            exp_rdy = comp ? 4'(1 << g) : 4'b0;
            exp_rd = comp ? rdata : 32'h0;
            total++; if (bus_start[sel] !== (st == 1) || busy[sel] !== (st != 0) || grant[sel] !== 2'(g)) begin
                bad++; $display("FAIL rnd%0d_ctl c=%0d: got s=%b b=%b g=%0d want %b/%b/%0d", sel, c, bus_start[sel], busy[sel], grant[sel], st == 1, st != 0, g); end
            total++; if (req_ready[sel] !== exp_rdy || req_data_rd[sel] !== exp_rd || overrun[sel] !== ovr) begin
                bad++; $display("FAIL rnd%0d_req c=%0d: got r=%b d=%h o=%b want %b/%h/%b", sel, c, req_ready[sel], req_data_rd[sel], overrun[sel], exp_rdy, exp_rd, ovr); end
            total++; if (bus_addr[sel] !== ba || bus_write[sel] !== bw || bus_data_wr[sel] !== bd || bus_data_be[sel] !== bb) begin
                bad++; $display("FAIL rnd%0d_bus c=%0d: got %h/%b/%h/%h want %h/%b/%h/%h", sel, c, bus_addr[sel], bus_write[sel], bus_data_wr[sel], bus_data_be[sel], ba, bw, bd, bb); end
            st_in = req_start[sel];
            if (comp) mp[g] = 0;
            for (int i = 0; i < N; i++)
                if (st_in[i]) begin
                    if (mp[i]) ovr[i] = 1'b1;
                    else begin
                        mp[i] = 1; mw[i] = req_write[sel][i]; ma[i] = req_addr[sel][i*AW +: AW];
                        md[i] = req_data_wr[sel][i*DW +: DW]; mb[i] = req_be[sel][i*BW +: BW];
                    end
                end
            if (st == 0 || comp) begin
                w = -1;
                for (int k = 1; k <= N; k++) begin
                    int cand;
                    cand = (sel == 0) ? (last + k) % N : k - 1;
                    if (w < 0 && mp[cand]) w = cand;
                end
                if (w >= 0) begin
                    st = 1; g = w; last = w;
                    ba = ma[w]; bw = mw[w]; bd = md[w]; bb = mb[w];
                    cd = $urandom_range(0, 2);
                end else st = 0;
            end else if (st == 1) st = 2;
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            req_start[s] = '0; req_write[s] = '0; req_addr[s] = '0; req_data_wr[s] = '0;
            req_be[s] = '0; bus_ready[s] = 1'b0; bus_data_rd[s] = '0;
        end
        test_reset();
        test_single_read();
        test_round_robin();
        test_fixed_priority();
        test_overrun();
        test_reset_mid();
        test_write_be();
        test_random(0, 400);
        test_random(1, 400);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
